// File: rtl/edac_crc_seq_decoder.sv
// Multi-cycle CRC EDAC decoder: folds BITS_PER_CYC codeword bits per clock into a syndrome,
// then (with EDAC_CORRECT_EN defined) walks x^i mod P to locate and flip a single-bit error.
module edac_crc_seq_decoder #(
  parameter int DATA_W       = 24,
  parameter int CRC_W        = 8,
  parameter int BITS_PER_CYC = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_i,
  input  logic [DATA_W+CRC_W-1:0]             din_i,
  input  logic [CRC_W-1:0]                    crc_poly_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic [DATA_W-1:0]                   dout_o,
  output logic                                valid_o,
  output logic                                err_det_o,
  output logic                                corrected_o,
  output logic [$clog2(DATA_W+CRC_W)-1:0]     err_pos_o
);

  // state   | meaning
  // IDLE    | waiting for start, results held
  // CALC    | folding codeword chunks into the syndrome
  // CHECK   | syndrome zero test
  // SEARCH  | stepping probe = x^pos mod P against the syndrome
  // DONE    | one-cycle result pulse
  localparam int CW_W  = DATA_W + CRC_W;
  localparam int N     = CW_W / BITS_PER_CYC;
  localparam int POS_W = $clog2(CW_W);
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CALC   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
`ifdef EDAC_CORRECT_EN
  localparam logic [2:0] S_SEARCH = 3'd3;
`endif
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CW_W-1:0]   cw_q, cw_d;
  logic [CRC_W-1:0]  poly_q, poly_d;
  logic [CRC_W-1:0]  syn_q, syn_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              err_det_q, err_det_d;
  logic              corrected_q, corrected_d;
  logic [CW_W-1:0]   cw_shift;

  // Polynomial long division, one bit at a time, MSB of the chunk first.
  function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] s,
                                            input logic [BITS_PER_CYC-1:0] bits,
                                            input logic [CRC_W-1:0] p);
    logic [CRC_W-1:0] r;
    r = s;
    for (int j = BITS_PER_CYC - 1; j >= 0; j--) begin
      r = {r[CRC_W-2:0], bits[j]} ^ ({CRC_W{r[CRC_W-1]}} & p);
    end
    return r;
  endfunction

  assign cw_shift = cw_q >> (cnt_q * BITS_PER_CYC);

`ifdef EDAC_CORRECT_EN
  logic [CRC_W-1:0] probe_q, probe_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [POS_W-1:0] err_pos_q, err_pos_d;
  logic [CW_W-1:0]  cw_flip;

  assign cw_flip = cw_q ^ (CW_W'(1) << pos_q);
`endif

  always_comb begin
    state_d     = state_q;
    cw_d        = cw_q;
    poly_d      = poly_q;
    syn_d       = syn_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    dout_d      = dout_q;
    valid_d     = valid_q;
    err_det_d   = err_det_q;
    corrected_d = corrected_q;
`ifdef EDAC_CORRECT_EN
    probe_d     = probe_q;
    pos_d       = pos_q;
    err_pos_d   = err_pos_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cw_d    = din_i;
          poly_d  = crc_poly_i;
          syn_d   = '0;
          cnt_d   = CNT_W'(N - 1);
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // Down-counter indexes the chunk, so the highest chunk is consumed first.
        syn_d = fold(syn_q, cw_shift[BITS_PER_CYC-1:0], poly_q);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (syn_q == '0) begin
          state_d     = S_DONE;
          dout_d      = cw_q[CW_W-1:CRC_W];
          valid_d     = 1'b1;
          err_det_d   = 1'b0;
          corrected_d = 1'b0;
`ifdef EDAC_CORRECT_EN
          err_pos_d   = '0;
`endif
        end else begin
`ifdef EDAC_CORRECT_EN
          probe_d = CRC_W'(1);
          pos_d   = '0;
          state_d = S_SEARCH;
`else
          state_d     = S_DONE;
          dout_d      = cw_q[CW_W-1:CRC_W];
          valid_d     = 1'b0;
          err_det_d   = 1'b1;
          corrected_d = 1'b0;
`endif
        end
      end
`ifdef EDAC_CORRECT_EN
      S_SEARCH: begin
        if (probe_q == syn_q) begin
          cw_d        = cw_flip;
          dout_d      = cw_flip[CW_W-1:CRC_W];
          valid_d     = 1'b1;
          err_det_d   = 1'b1;
          corrected_d = 1'b1;
          err_pos_d   = pos_q;
          state_d     = S_DONE;
        end else if (pos_q == POS_W'(CW_W - 1)) begin
          dout_d      = cw_q[CW_W-1:CRC_W];
          valid_d     = 1'b0;
          err_det_d   = 1'b1;
          corrected_d = 1'b0;
          err_pos_d   = '0;
          state_d     = S_DONE;
        end else begin
          probe_d = {probe_q[CRC_W-2:0], 1'b0} ^ ({CRC_W{probe_q[CRC_W-1]}} & poly_q);
          pos_d   = pos_q + POS_W'(1);
        end
      end
`endif
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cw_q        <= '0;
      poly_q      <= '0;
      syn_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      err_det_q   <= 1'b0;
      corrected_q <= 1'b0;
`ifdef EDAC_CORRECT_EN
      probe_q     <= '0;
      pos_q       <= '0;
      err_pos_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cw_q        <= cw_d;
      poly_q      <= poly_d;
      syn_q       <= syn_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      err_det_q   <= err_det_d;
      corrected_q <= corrected_d;
`ifdef EDAC_CORRECT_EN
      probe_q     <= probe_d;
      pos_q       <= pos_d;
      err_pos_q   <= err_pos_d;
`endif
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign dout_o      = dout_q;
  assign valid_o     = valid_q;
  assign err_det_o   = err_det_q;
  assign corrected_o = corrected_q;
`ifdef EDAC_CORRECT_EN
  assign err_pos_o   = err_pos_q;
`else
  assign err_pos_o   = '0;
`endif

endmodule

// File: tb/tb_edac_crc_seq_decoder.sv
// Directed bench for edac_crc_seq_decoder (24 data bits, CRC-8, poly 0x97, 4 bits/clock).
// Expected values follow EDAC_CORRECT_EN when it is defined for the build.
module tb_edac_crc_seq_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] din_i;
  logic [7:0]  crc_poly_i;
  logic        busy_o;
  logic        done_o;
  logic [23:0] dout_o;
  logic        valid_o;
  logic        err_det_o;
  logic        corrected_o;
  logic [4:0]  err_pos_o;

  int checks = 0;
  int errors = 0;

  edac_crc_seq_decoder #(.DATA_W(24), .CRC_W(8), .BITS_PER_CYC(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .din_i       (din_i),
    .crc_poly_i  (crc_poly_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .dout_o      (dout_o),
    .valid_o     (valid_o),
    .err_det_o   (err_det_o),
    .corrected_o (corrected_o),
    .err_pos_o   (err_pos_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Latency counts edges from acceptance up to the edge that closes the done cycle.
  task automatic wait_done(output int lat);
    int m;
    m = 0;
    while (done_o !== 1'b1 && m < 100) begin
      @(posedge clk); #1;
      m++;
    end
    lat = m + 1;
  endtask

  task automatic txn(input string tag, input logic [31:0] din, input int exp_lat,
                     input logic [23:0] exp_dout, input logic exp_valid, input logic exp_err,
                     input logic exp_corr, input logic [4:0] exp_pos);
    int lat;
    din_i      = din;
    crc_poly_i = 8'h97;
    start_i    = 1'b1;
    @(posedge clk); #1;
    start_i    = 1'b0;
    chk({tag, " busy_after_accept"}, busy_o, 1);
    wait_done(lat);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy_in_done"}, busy_o, 1);
    chk({tag, " dout"}, dout_o, exp_dout);
    chk({tag, " valid"}, valid_o, exp_valid);
    chk({tag, " err_det"}, err_det_o, exp_err);
    chk({tag, " corrected"}, corrected_o, exp_corr);
    chk({tag, " err_pos"}, err_pos_o, exp_pos);
    @(posedge clk); #1;
    chk({tag, " done_pulse_end"}, done_o, 0);
    chk({tag, " busy_end"}, busy_o, 0);
    chk({tag, " dout_held"}, dout_o, exp_dout);
  endtask

  initial begin
    int lat;
    rst        = 1'b1;
    start_i    = 1'b0;
    din_i      = '0;
    crc_poly_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    chk("rst valid", valid_o, 0);
    chk("rst dout", dout_o, 0);
    chk("rst err_pos", err_pos_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    txn("clean_197", 32'h00000197, 10, 24'h000001, 1'b1, 1'b0, 1'b0, 5'd0);
    txn("clean_2fa", 32'h0002FA7F, 10, 24'h0002FA, 1'b1, 1'b0, 1'b0, 5'd0);
`ifdef EDAC_CORRECT_EN
    txn("flip19", 32'h000AFA7F, 30, 24'h0002FA, 1'b1, 1'b1, 1'b1, 5'd19);
    txn("flip4", 32'h00000187, 15, 24'h000001, 1'b1, 1'b1, 1'b1, 5'd4);
    // Bits 0 and 1 flipped: syndrome 0x03 is not x^i mod P for any i in 0..31.
    txn("double", 32'h00000194, 42, 24'h000001, 1'b0, 1'b1, 1'b0, 5'd0);
`else
    txn("flip19", 32'h000AFA7F, 10, 24'h000AFA, 1'b0, 1'b1, 1'b0, 5'd0);
    txn("flip4", 32'h00000187, 10, 24'h000001, 1'b0, 1'b1, 1'b0, 5'd0);
    txn("double", 32'h00000194, 10, 24'h000001, 1'b0, 1'b1, 1'b0, 5'd0);
`endif

    // start held high through the whole transaction; Din changes must not leak in.
    din_i      = 32'h0002FA7F;
    crc_poly_i = 8'h97;
    start_i    = 1'b1;
    @(posedge clk); #1;
    din_i = 32'h12345678;
    wait_done(lat);
    chk("held latency", lat, 10);
    chk("held dout", dout_o, 24'h0002FA);
    chk("held valid", valid_o, 1);
    start_i = 1'b0;
    @(posedge clk); #1;
    chk("held start_in_done_ignored", busy_o, 0);
    @(posedge clk); #1;
    chk("held still_idle", busy_o, 0);

    // Reset in the middle of CALC clears the held result.
    din_i   = 32'h000AFA7F;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst busy", busy_o, 0);
    chk("midrst done", done_o, 0);
    chk("midrst valid", valid_o, 0);
    chk("midrst err_det", err_det_o, 0);
    chk("midrst corrected", corrected_o, 0);
    chk("midrst dout", dout_o, 0);
    chk("midrst err_pos", err_pos_o, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    txn("after_rst", 32'h00000197, 10, 24'h000001, 1'b1, 1'b0, 1'b0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
